// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage: consumes ALU bundles, performs loads and
// stores against a word-addressed RAM, drives the register-file write port.
module mem_wb_stage #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_data2,
  input  logic [31:0] alu_cpsr,
  input  logic        alu_w,
  input  logic        alu_m,
  input  logic [31:0] alu_dst,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] cpsr,
  output logic        fault,
  output logic [31:0] retired
);

  typedef enum logic {
    IDLE    = 1'b0,
    LD_WAIT = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [31:0] mem [DEPTH];
  logic [31:0] ld_data_q;
  logic        ld_oor_q;
  logic [31:0] retired_q;

  logic          accept;
  logic          is_alu, is_load, is_store;
  logic [31:0]   mem_addr;
  logic [AW-1:0] mem_idx;
  logic          addr_oor, addr_misaligned, dst_bad;
  logic          fault_now;

  assign alu_ready = (state_q == IDLE);
  assign accept    = alu_valid && alu_ready;
  assign is_alu    = !alu_m;
  assign is_load   = alu_m && alu_w;
  assign is_store  = alu_m && !alu_w;

  // Loads carry their address in data2, stores carry it in dst.
  assign mem_addr        = is_load ? alu_data2 : alu_dst;
  assign mem_idx         = mem_addr[AW+1:2];
  assign addr_oor        = |mem_addr[31:AW+2];
  assign addr_misaligned = |mem_addr[1:0];
  assign dst_bad         = |alu_dst[31:4];
  assign retired         = retired_q;

  always_comb begin
    fault_now = 1'b0;
    if (accept) begin
      if (alu_m) fault_now = addr_oor || addr_misaligned || (is_load && dst_bad);
      else       fault_now = alu_w && dst_bad;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && is_load) state_d = LD_WAIT;
      LD_WAIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: RAM and the load capture registers have no reset; the array cannot
  // be cleared in one cycle and contents must survive reset anyway.
  always_ff @(posedge clk) begin
    if (accept && is_store && !addr_oor) mem[mem_idx] <= alu_data2;
    if (accept && is_load) begin
      ld_data_q <= mem[mem_idx];
      ld_oor_q  <= addr_oor;
    end
  end

  // NOTE: all state here uses non-blocking assignment so every read in this
  // block sees the pre-edge value, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      cpsr      <= '0;
      fault     <= 1'b0;
      retired_q <= '0;
    end else begin
      rf_we <= 1'b0;
      if (fault_now) fault <= 1'b1;
      if (state_q == LD_WAIT) begin
        rf_we     <= 1'b1;
        rf_wdata  <= ld_oor_q ? 32'h0 : ld_data_q;
        retired_q <= retired_q + 32'd1;
      end else if (accept) begin
        if (is_alu) begin
          cpsr      <= alu_cpsr;
          retired_q <= retired_q + 32'd1;
          if (alu_w) begin
            rf_we    <= 1'b1;
            rf_waddr <= alu_dst[3:0];
            rf_wdata <= alu_result;
          end
        end else if (is_load) begin
          rf_waddr <= alu_dst[3:0];
        end else begin
          retired_q <= retired_q + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_mem_wb_stage;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [31:0] alu_result = '0, alu_data2 = '0, alu_cpsr = '0, alu_dst = '0;
  logic        alu_w = 1'b0, alu_m = 1'b0;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata, cpsr, retired;
  logic        fault;

  mem_wb_stage #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_result(alu_result), .alu_data2(alu_data2), .alu_cpsr(alu_cpsr),
    .alu_w(alu_w), .alu_m(alu_m), .alu_dst(alu_dst), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .cpsr(cpsr), .fault(fault),
    .retired(retired)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model: expected outputs after each rising edge.
  logic        exp_we = 1'b0, exp_fault = 1'b0, exp_after_rst = 1'b0, pend = 1'b0;
  logic [3:0]  exp_waddr = '0, pend_reg = '0;
  logic [31:0] exp_wdata = '0, exp_cpsr = '0, exp_retired = '0, pend_data = '0;
  logic [31:0] mem_m [DEPTH];
  int          preset_cnt = 0, preset_seen = 0;
  logic        chk_en = 1'b0;

  initial forever begin
    @(posedge clk);
    if (preset_cnt != preset_seen) begin
      exp_retired = 32'hFFFF_FFFE;
      preset_seen = preset_cnt;
    end
    exp_after_rst = reset;
    if (reset) begin
      exp_we = 0; exp_waddr = 0; exp_wdata = 0; exp_cpsr = 0;
      exp_fault = 0; exp_retired = 0; pend = 0;
    end else begin
      exp_we = 0;
      if (pend) begin
        exp_we      = 1;
        exp_waddr   = pend_reg;
        exp_wdata   = pend_data;
        exp_retired = exp_retired + 1;
        pend        = 0;
      end else if (alu_valid) begin
        if (!alu_m) begin
          exp_cpsr    = alu_cpsr;
          exp_retired = exp_retired + 1;
          if (alu_w) begin
            exp_we    = 1;
            exp_waddr = 4'(alu_dst % 16);
            exp_wdata = alu_result;
            if (alu_dst > 15) exp_fault = 1;
          end
        end else if (alu_w) begin
          if (alu_data2 >= 32'(DEPTH * 4)) begin
            pend_data = 0;
            exp_fault = 1;
          end else begin
            pend_data = mem_m[int'(alu_data2 / 4)];
          end
          if (alu_data2 % 4 != 0) exp_fault = 1;
          if (alu_dst > 15) exp_fault = 1;
          pend_reg = 4'(alu_dst % 16);
          pend     = 1;
        end else begin
          if (alu_dst >= 32'(DEPTH * 4)) exp_fault = 1;
          else mem_m[int'(alu_dst / 4)] = alu_data2;
          if (alu_dst % 4 != 0) exp_fault = 1;
          exp_retired = exp_retired + 1;
        end
      end
    end
  end

  // Single compare process, half a cycle away from the active edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("rf_we", 32'(rf_we), 32'(exp_we));
      if (exp_we || exp_after_rst) begin
        check("rf_waddr", 32'(rf_waddr), 32'(exp_waddr));
        check("rf_wdata", rf_wdata, exp_wdata);
      end
      check("cpsr", cpsr, exp_cpsr);
      check("fault", 32'(fault), 32'(exp_fault));
      check("alu_ready", 32'(alu_ready), 32'(!pend));
      if (preset_cnt == preset_seen) check("retired", retired, exp_retired);
    end
  end

  // Drive one bundle and hold it until accepted; returns 1ns after the accept edge.
  task automatic issue(input logic m, input logic w, input logic [31:0] res,
                       input logic [31:0] d2, input logic [31:0] cp, input logic [31:0] dst);
    int n = 0;
    @(negedge clk);
    alu_m = m; alu_w = w; alu_result = res; alu_data2 = d2; alu_cpsr = cp; alu_dst = dst;
    alu_valid = 1'b1;
    while (!alu_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!alu_ready) begin
      check("accept_timeout", 32'(alu_ready), 32'd1);
      alu_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 alu_valid = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  logic        consumed;
  logic [31:0] addr, dreg;
  int          r;

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    check("rst_ready", 32'(alu_ready), 32'd1);
    check("rst_retired", retired, 32'd0);

    // ALU op with write-back
    issue(1'b0, 1'b1, 32'h2A, 32'h0, 32'h4000_0000, 32'd3);
    check("t1_we", 32'(rf_we), 32'd1);
    check("t1_waddr", 32'(rf_waddr), 32'd3);
    check("t1_wdata", rf_wdata, 32'h2A);
    check("t1_cpsr", cpsr, 32'h4000_0000);
    check("t1_retired", retired, 32'd1);
    check("t1_ready", 32'(alu_ready), 32'd1);
    @(posedge clk); #1;
    check("t1_we_pulse", 32'(rf_we), 32'd0);

    // Store then back-to-back load of the same word
    issue(1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF, 32'hFFFF_0000, 32'h10);
    issue(1'b1, 1'b1, 32'h1, 32'h10, 32'hFFFF_0000, 32'd5);
    check("t2_bubble", 32'(alu_ready), 32'd0);
    check("t2_no_we_e0", 32'(rf_we), 32'd0);
    @(posedge clk); #1;
    check("t2_we", 32'(rf_we), 32'd1);
    check("t2_waddr", 32'(rf_waddr), 32'd5);
    check("t2_wdata", rf_wdata, 32'hDEAD_BEEF);
    check("t2_ready", 32'(alu_ready), 32'd1);
    check("t2_cpsr", cpsr, 32'h4000_0000);
    check("t2_retired", retired, 32'd3);

    // Compare-style op: no write, cpsr updated
    issue(1'b0, 1'b0, 32'h99, 32'h0, 32'h8000_0000, 32'd7);
    check("t4_no_we", 32'(rf_we), 32'd0);
    check("t4_cpsr", cpsr, 32'h8000_0000);
    check("t4_fault", 32'(fault), 32'd0);

    // Out-of-range load: returns 0, fault sticks
    issue(1'b1, 1'b1, 32'h1, 32'h0000_1000, 32'h0, 32'd2);
    @(posedge clk); #1;
    check("t3_we", 32'(rf_we), 32'd1);
    check("t3_wdata", rf_wdata, 32'h0);
    check("t3_fault", 32'(fault), 32'd1);
    issue(1'b0, 1'b1, 32'h5, 32'h0, 32'h1, 32'd1);
    repeat (3) @(posedge clk);
    #1 check("t3_fault_sticky", 32'(fault), 32'd1);
    check("t3_retired", retired, 32'd6);

    // Reset while a load is waiting
    pulse_reset();
    check("t5_fault_clr", 32'(fault), 32'd0);
    issue(1'b1, 1'b0, 32'h0, 32'h1234_5678, 32'h0, 32'h20);
    issue(1'b1, 1'b1, 32'h1, 32'h20, 32'h0, 32'd9);
    reset = 1'b1;
    @(posedge clk); #1;
    check("t5_no_we", 32'(rf_we), 32'd0);
    check("t5_retired", retired, 32'd0);
    check("t5_waddr", 32'(rf_waddr), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("t5_ready", 32'(alu_ready), 32'd1);
    issue(1'b1, 1'b1, 32'h1, 32'h20, 32'h0, 32'd9);
    @(posedge clk); #1;
    check("t5_reload", rf_wdata, 32'h1234_5678);
    check("t5_retired1", retired, 32'd1);
    issue(1'b1, 1'b1, 32'h1, 32'h10, 32'h0, 32'd4);
    @(posedge clk); #1;
    check("t5_ram_kept", rf_wdata, 32'hDEAD_BEEF);

    // Counter wrap
    force dut.retired_q = 32'hFFFF_FFFE;
    #1 release dut.retired_q;
    preset_cnt++;
    issue(1'b0, 1'b1, 32'h7, 32'h0, 32'h0, 32'd4);
    check("t6_max", retired, 32'hFFFF_FFFF);
    issue(1'b0, 1'b1, 32'h8, 32'h0, 32'h0, 32'd4);
    check("t6_wrap", retired, 32'd0);

    // Give every RAM word a known value before random loads
    for (int i = 0; i < DEPTH; i++) issue(1'b1, 1'b0, 32'h0, $urandom, 32'h0, 32'(i * 4));

    consumed = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (!alu_valid || consumed) begin
        r          = int'($urandom_range(0, 99));
        alu_m      = ($urandom_range(0, 2) != 0);
        alu_w      = 1'($urandom_range(0, 1));
        alu_result = $urandom;
        alu_cpsr   = $urandom;
        addr       = 32'($urandom_range(0, DEPTH - 1)) << 2;
        if (r == 0) addr = $urandom | 32'h400;
        if (r == 1) addr = addr | 32'($urandom_range(1, 3));
        dreg = 32'($urandom_range(0, 15));
        if (r == 2) dreg = $urandom | 32'h10;
        if (alu_m && !alu_w) begin
          alu_dst = addr; alu_data2 = $urandom;
        end else if (alu_m) begin
          alu_dst = dreg; alu_data2 = addr;
        end else begin
          alu_dst = dreg; alu_data2 = $urandom;
        end
        alu_valid = ($urandom_range(0, 3) != 0);
      end
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 149) == 0) reset = 1'b1;
      consumed = alu_valid && alu_ready && !reset;
    end
    @(negedge clk);
    alu_valid = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
